mem_ab_loader: RTL and testbench

- Upstream sequencer for the memA/memB input-staging buffers of the systolic array.
- Accepts DIM row beats over a valid/ready stream; each beat carries one A row and one B row.
- Writes each beat into memA/memB through the shared WrEn/Arow/Ain/Bin interface.
- Then asserts en for exactly 3*DIM-2 cycles so both memories skew their contents into the array, and finally pulses done.

---
 rtl/mem_ab_loader_if.sv | 19 +
 rtl/mem_ab_loader.sv | 64 ++++++
 tb/tb_mem_ab_loader.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mem_ab_loader_if.sv
// mem_ab_loader_if: row-beat input stream and the shared memA/memB write/shift bus.
interface ab_stream_if #(parameter int BITS_AB = 8, parameter int DIM = 8);
  logic in_valid;
  logic in_ready;
  logic signed [BITS_AB-1:0] in_A [DIM];
  logic signed [BITS_AB-1:0] in_B [DIM];
  modport master (output in_valid, in_A, in_B, input in_ready);
  modport slave (input in_valid, in_A, in_B, output in_ready);
endinterface

interface ab_mem_if #(parameter int BITS_AB = 8, parameter int DIM = 8);
  logic WrEn;
  logic en;
  logic [$clog2(DIM)-1:0] Arow;
  logic signed [BITS_AB-1:0] Ain [DIM];
  logic signed [BITS_AB-1:0] Bin [DIM];
  modport master (output WrEn, Arow, Ain, Bin, en);
  modport slave (input WrEn, Arow, Ain, Bin, en);
endinterface

// File: rtl/mem_ab_loader.sv
// mem_ab_loader: writes DIM A/B row beats into memA/memB, then drives en for the
// skew phase and pulses done.
module mem_ab_loader #(
  parameter int BITS_AB = 8,
  parameter int DIM = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  ab_stream_if.slave s,
  ab_mem_if.master m,
  output logic busy,
  output logic done
);
  localparam int EN_CYCLES = DIM * 3 - 2;
  localparam int RW = $clog2(DIM);
  localparam int CW = $clog2(EN_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [RW-1:0] row_cnt;
  logic [CW-1:0] run_cnt;
  logic accept, last_beat, run_end;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    accept = state == LOAD && s.in_valid;
    last_beat = accept && row_cnt == RW'(DIM - 1);
    run_end = state == RUN && run_cnt == CW'(EN_CYCLES);
    state_nx = (state == IDLE && start) ? LOAD :
               last_beat ? RUN :
               run_end ? DONE :
               state == DONE ? IDLE : state;
    s.in_ready = state == LOAD;
    busy = state == LOAD || state == RUN;
    done = state == DONE;
  end
  // en is asserted on every RUN edge until run_cnt reaches EN_CYCLES, so it
  // starts right after the final write cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt <= '0;
      run_cnt <= '0;
      m.WrEn <= 1'b0;
      m.en <= 1'b0;
      m.Arow <= '0;
      for (int i = 0; i < DIM; i++) begin
        m.Ain[i] <= '0;
        m.Bin[i] <= '0;
      end
    end else begin
      m.WrEn <= accept;
      m.en <= state == RUN && !run_end;
      row_cnt <= state == IDLE ? '0 : accept ? row_cnt + 1'b1 : row_cnt;
      run_cnt <= state == RUN ? run_cnt + CW'(!run_end) : '0;
      if (accept) begin
        m.Arow <= row_cnt;
        m.Ain <= s.in_A;
        m.Bin <= s.in_B;
      end
    end
  end
endmodule

// File: tb/tb_mem_ab_loader.sv
// tb_mem_ab_loader: table-driven load/run sequences with a write scoreboard,
// plus hand-written reset and abort sequences.
module tb_mem_ab_loader;
  localparam int BITS_AB = 8;
  localparam int DIM = 8;
  localparam int EN_CYCLES = 3 * DIM - 2;
  localparam int AW = $clog2(DIM);
  localparam int PW = DIM * BITS_AB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done;

  always #5 clk = ~clk;

  ab_stream_if #(.BITS_AB(BITS_AB), .DIM(DIM)) sif ();
  ab_mem_if #(.BITS_AB(BITS_AB), .DIM(DIM)) mif ();

  mem_ab_loader #(.BITS_AB(BITS_AB), .DIM(DIM)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .s(sif), .m(mif), .busy(busy), .done(done)
  );

  typedef struct {
    logic [31:0] mask;
    bit rnd;
    bit start_busy;
    bit start_done;
    int exp_wr;
    int exp_en;
    int exp_lat;
  } vec_t;

  typedef struct {
    logic [AW-1:0] row;
    logic signed [BITS_AB-1:0] a [DIM];
    logic signed [BITS_AB-1:0] b [DIM];
  } wr_t;

  wr_t q[$];
  int checks = 0;
  int passes = 0;
  vec_t tbl [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [PW-1:0] pack(input logic signed [BITS_AB-1:0] x [DIM]);
    logic [PW-1:0] r;
    for (int i = 0; i < DIM; i++) r[i*BITS_AB +: BITS_AB] = x[i];
    return r;
  endfunction

  task automatic run_seq(input vec_t v);
    int beats = 0, cyc = 0, wr = 0, enc = 0, dn = 0, lat = 0, ovl = 0;
    bit prev_wr = 0, prev_en = 0, en_bad = 0, fin = 0;
    wr_t w;
    @(negedge clk);
    start = 1'b1;
    while (!fin && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (mif.WrEn) begin
        wr++;
        chk("wr_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          w = q.pop_front();
          chk("wr_row", mif.Arow, w.row);
          chk("wr_a", pack(mif.Ain), pack(w.a));
          chk("wr_b", pack(mif.Bin), pack(w.b));
        end
      end
      if (mif.WrEn && mif.en) ovl++;
      if (mif.en) begin
        if (enc == 0) chk("en_after_last_wr", prev_wr, 1);
        else if (!prev_en) en_bad = 1;
        enc++;
      end
      prev_wr = mif.WrEn;
      prev_en = mif.en;
      if (done) begin
        dn++;
        lat = cyc;
        fin = 1;
        chk("done_busy_low", busy, 0);
      end
      start = fin ? v.start_done : (v.start_busy && busy);
      if (beats < DIM) begin
        sif.in_valid = cyc <= 32 ? v.mask[cyc-1] : 1'b1;
        for (int c = 0; c < DIM; c++) begin
          sif.in_A[c] = v.rnd ? BITS_AB'($urandom) : BITS_AB'(beats * 8 + c);
          sif.in_B[c] = v.rnd ? BITS_AB'($urandom) : BITS_AB'(-(beats * 8 + c));
        end
        if (sif.in_valid && sif.in_ready) begin
          w.row = AW'(beats);
          for (int c = 0; c < DIM; c++) begin
            w.a[c] = sif.in_A[c];
            w.b[c] = sif.in_B[c];
          end
          q.push_back(w);
          beats++;
        end
      end else begin
        sif.in_valid = v.rnd && !fin ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
    if (v.start_done) begin
      @(negedge clk);
      chk("start_in_done_ignored", busy, 0);
      start = 1'b0;
    end
    start = 1'b0;
    sif.in_valid = 1'b0;
    chk("wr_count", wr, v.exp_wr);
    chk("en_count", enc, v.exp_en);
    chk("en_contiguous", en_bad, 0);
    chk("done_count", dn, 1);
    chk("latency", lat, v.exp_lat);
    chk("wr_en_overlap", ovl, 0);
    chk("scoreboard_empty", q.size(), 0);
  endtask

  initial begin
    int enc, k;
    bit seen, dn;
    tbl[0] = '{32'hFFFF_FFFF, 0, 0, 0, DIM, EN_CYCLES, 32};
    tbl[1] = '{32'h0024_9249, 0, 1, 0, DIM, EN_CYCLES, 46};
    tbl[2] = '{32'h5555_5555, 1, 0, 1, DIM, EN_CYCLES, 39};
    tbl[3] = '{32'h0000_07F8, 1, 1, 1, DIM, EN_CYCLES, 35};
    sif.in_valid = 1'b0;
    for (int c = 0; c < DIM; c++) begin
      sif.in_A[c] = '0;
      sif.in_B[c] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_in_ready", sif.in_ready, 0);
    chk("rst_wren", mif.WrEn, 0);
    chk("rst_arow", mif.Arow, 0);
    chk("rst_ain", pack(mif.Ain), 0);
    chk("rst_bin", pack(mif.Bin), 0);
    chk("rst_en", mif.en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      sif.in_valid = ~sif.in_valid;
      @(negedge clk);
      seen |= mif.WrEn | sif.in_ready | busy;
    end
    sif.in_valid = 1'b0;
    chk("idle_ignores_valid", seen, 0);

    for (int i = 0; i < 4; i++) run_seq(tbl[i]);

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    enc = 0;
    k = 0;
    while (enc < 10 && k < 100) begin
      sif.in_valid = k < DIM;
      @(negedge clk);
      if (mif.en) enc++;
      k++;
    end
    sif.in_valid = 1'b0;
    chk("abort_reached_run", enc, 10);
    rst_n = 1'b0;
    #1;
    chk("abort_en", mif.en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_wren", mif.WrEn, 0);
    dn = done;
    repeat (3) begin
      @(negedge clk);
      dn |= done;
    end
    chk("abort_no_done", dn, 0);
    rst_n = 1'b1;
    q.delete();
    run_seq(tbl[0]);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
